matrix_mem_bridge: RTL and testbench
====================================

Name: matrix_mem_bridge

Overview:
- Memory-side stage directly downstream of the matrix multiplication engine.
- Turns the engine's level-held request (mem_operation/addr/data, completed by an opdone pulse) into single-word accesses on a word-addressed on-chip SRAM macro.
- Also arbitrates a host request/ack port onto the same SRAM, used to load parameters and operand matrices and to read back results.
- Returns read data and opdone to the engine in the same cycle.

Parameters:
- ADDR_WIDTH, 9: SRAM word-address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: cycles from SRAM select to valid sram_dout (1..3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- eng_mem_operation  in  2  engine request: 00 none, 01 read, 11 write (10 treated as none)
- eng_addr  in  32  engine word address
- eng_wdata  in  32  engine write data
- eng_rdata  out  32  read data to engine; valid when eng_opdone=1
- eng_opdone  out  1  one-cycle completion pulse to engine
- host_req  in  1  host request, held until host_ack
- host_we  in  1  1 write, 0 read
- host_addr  in  32  host word address
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data; valid with host_ack
- host_ack  out  1  one-cycle host completion pulse
- sram_csb  out  1  SRAM chip select, active low
- sram_web  out  1  SRAM write enable, active low
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data
- err_oob  out  1  sticky out-of-range flag

Behaviour:
- Reset (async assert, sync release): state IDLE; eng_opdone=0, host_ack=0; eng_rdata=0, host_rdata=0; sram_csb=1, sram_web=1, sram_addr=0, sram_din=0; err_oob=0; last_grant=HOST (engine wins first tie).
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP, HOLD.
- IDLE: an engine request is eng_mem_operation in {01,11}.
  - Arbitration only when both engine and host_req request in the same cycle; grant goes to the requester not in last_grant (round-robin).
  - A single requester is granted immediately.
  - On grant: latch owner, we, addr, wdata; update last_grant; go to ACCESS.
- ACCESS (1 cycle): drive sram_csb=0, sram_web=~we, sram_addr=addr[ADDR_WIDTH-1:0], sram_din=wdata.
  - Write: go to RESP.
  - Read: go to WAIT with latency counter = READ_LATENCY.
- Out-of-range request (addr >= DEPTH, any of bits 31:ADDR_WIDTH set): no SRAM select; writes dropped; reads return 0; err_oob set, stays set until reset; still completes via RESP.
- WAIT: sram_csb=1; decrement counter; at 0 capture sram_dout into owner's rdata register; go to RESP.
- RESP (1 cycle): pulse owner's done (eng_opdone or host_ack), with rdata valid the same cycle; go to HOLD.
- HOLD (1 cycle): ignore all requests and go to IDLE.
  - Reason: the engine drops or changes its request on the same edge it samples opdone, so without HOLD the stale request would be re-issued.
- Latency from a granted request to the done pulse:
  - write: 2 cycles (ACCESS, RESP);
  - read: 2+READ_LATENCY cycles;
  - the next grant is possible 4 (write) / 4+READ_LATENCY (read) cycles after the previous grant.
- A request is sampled only in IDLE; later changes to addr/data/op by the requester have no effect on an access already in progress.
- A request withdrawn before grant is simply not served.
- Back-to-back engine reads (incrementing address, op held at 01) each produce one opdone.
- Bridge does not inspect engine state; the engine sitting in IDLE/DONE is just op=00.
- Arithmetic: no address translation; the bridge passes the engine's word addresses unchanged (parameter header at 0..3, matrices from 4).
- Reset mid-access: access abandoned; no done pulse; SRAM deselected immediately.

Decomposition:
- Shared package: mem_operation encodings (MEM_NONE=00, MEM_READ=01, MEM_WRITE=11), FSM state enum, owner enum (OWN_ENG, OWN_HOST).
- Both the engine and the bridge import the package.
- One natural sub-module, mem_rr_arbiter: two-requester round-robin with last_grant register and update strobe.

Test Plan:
- Reset: release reset_n with no requests -> sram_csb=1, all done pulses 0, err_oob=0 for 20 cycles.
- Host write then engine read: host writes 0x0000_0002 to addr 0 -> host_ack pulses 2 cycles after grant. Engine then reads addr 0 with READ_LATENCY=1 -> eng_opdone pulses once, 3 cycles after grant, with eng_rdata=0x0000_0002.
- Engine parameter fetch: engine holds op=01 and steps addr 0..4 on each opdone -> exactly 5 opdone pulses; each pulse carries the host-preloaded word for that address.
- Simultaneous requests: engine and host request on the same cycle twice in a row -> grants alternate ENG, HOST, ENG, HOST; neither is starved.
- Out-of-range: engine writes 0xDEAD_BEEF to addr 0x0000_0200 with ADDR_WIDTH=9 -> no SRAM select, eng_opdone still pulses, err_oob=1 and stays 1. Host readback of addr 0 is unchanged.
- Reset mid-read: assert reset_n low during WAIT -> sram_csb=1 and eng_opdone=0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/matrix_mem_bridge_pkg.sv
// rtl/matrix_mem_bridge_pkg.sv - shared encodings for the matrix engine memory bridge
package matrix_mem_bridge_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_e;

  typedef enum logic {
    OWN_ENG  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/matrix_mem_bridge_arbiter.sv
// rtl/matrix_mem_bridge_arbiter.sv - two-requester round-robin arbiter (engine vs host)
module mem_rr_arbiter
  import matrix_mem_bridge_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   req_eng,
  input  logic   req_host,
  input  logic   update,
  output logic   grant_valid,
  output owner_e grant_owner
);

  owner_e last_grant;

  // Reset to HOST so the engine wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWN_HOST;
    end else if (update && grant_valid) begin
      last_grant <= grant_owner;
    end
  end

  always_comb begin
    grant_valid = req_eng | req_host;
    grant_owner = OWN_HOST;
    if (req_eng && req_host) begin
      grant_owner = (last_grant == OWN_HOST) ? OWN_ENG : OWN_HOST;
    end else if (req_eng) begin
      grant_owner = OWN_ENG;
    end
  end

endmodule

// File: rtl/matrix_mem_bridge.sv
// rtl/matrix_mem_bridge.sv - engine/host request arbitration onto a single-port word SRAM
module matrix_mem_bridge
  import matrix_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            eng_mem_operation,
  input  logic [31:0]           eng_addr,
  input  logic [31:0]           eng_wdata,
  output logic [31:0]           eng_rdata,
  output logic                  eng_opdone,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [31:0]           host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic                  host_ack,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout,
  output logic                  err_oob
);

  localparam logic [1:0] RL = 2'(READ_LATENCY);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  oob_q, oob_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  finish;

  logic                  csb_d, web_d, eng_done_d, host_ack_d, err_d;
  logic [ADDR_WIDTH-1:0] sram_addr_d;
  logic [31:0]           din_d, eng_rdata_d, host_rdata_d, rd_word;

  logic                  idle, eng_req, grant_valid;
  owner_e                grant_owner;
  logic [31:0]           g_addr, g_wdata;
  logic                  g_we, g_oob;

  assign idle    = (state_q == ST_IDLE);
  assign eng_req = (eng_mem_operation == MEM_READ) || (eng_mem_operation == MEM_WRITE);

  // Requests are only visible to the arbiter in IDLE, so HOLD swallows stale ones.
  mem_rr_arbiter u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_eng     (eng_req && idle),
    .req_host    (host_req && idle),
    .update      (grant_valid),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign g_addr  = (grant_owner == OWN_ENG) ? eng_addr  : host_addr;
  assign g_wdata = (grant_owner == OWN_ENG) ? eng_wdata : host_wdata;
  assign g_we    = (grant_owner == OWN_ENG) ? (eng_mem_operation == MEM_WRITE) : host_we;
  assign g_oob   = |g_addr[31:ADDR_WIDTH];
  assign rd_word = oob_q ? 32'h0 : sram_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    oob_d        = oob_q;
    cnt_d        = cnt_q;
    finish       = 1'b0;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    sram_addr_d  = sram_addr;
    din_d        = sram_din;
    eng_done_d   = 1'b0;
    host_ack_d   = 1'b0;
    eng_rdata_d  = eng_rdata;
    host_rdata_d = host_rdata;
    err_d        = err_oob;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d     = ST_ACCESS;
          owner_d     = grant_owner;
          we_d        = g_we;
          oob_d       = g_oob;
          csb_d       = g_oob;
          web_d       = ~g_we | g_oob;
          sram_addr_d = g_addr[ADDR_WIDTH-1:0];
          din_d       = g_wdata;
          err_d       = err_oob | g_oob;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_RESP;
          finish  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = RL;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 2'd1) begin
          state_d = ST_RESP;
          finish  = 1'b1;
          if (owner_q == OWN_ENG) eng_rdata_d = rd_word;
          else                    host_rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      eng_done_d = (owner_q == OWN_ENG);
      host_ack_d = (owner_q == OWN_HOST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_ENG;
      we_q       <= 1'b0;
      oob_q      <= 1'b0;
      cnt_q      <= 2'd0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_addr  <= '0;
      sram_din   <= 32'h0;
      eng_opdone <= 1'b0;
      host_ack   <= 1'b0;
      eng_rdata  <= 32'h0;
      host_rdata <= 32'h0;
      err_oob    <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      we_q       <= we_d;
      oob_q      <= oob_d;
      cnt_q      <= cnt_d;
      sram_csb   <= csb_d;
      sram_web   <= web_d;
      sram_addr  <= sram_addr_d;
      sram_din   <= din_d;
      eng_opdone <= eng_done_d;
      host_ack   <= host_ack_d;
      eng_rdata  <= eng_rdata_d;
      host_rdata <= host_rdata_d;
      err_oob    <= err_d;
    end
  end

endmodule

// File: tb/tb_matrix_mem_bridge.sv
// tb/tb_matrix_mem_bridge.sv - scoreboard bench for matrix_mem_bridge
module tb_matrix_mem_bridge;
  import matrix_mem_bridge_pkg::*;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    eng_mem_operation = 2'b00;
  logic [31:0]   eng_addr = '0, eng_wdata = '0, eng_rdata;
  logic          eng_opdone;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [31:0]   host_addr = '0, host_wdata = '0, host_rdata;
  logic          host_ack;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [31:0]   sram_dout = '0;
  logic          err_oob;

  always #5 clk = ~clk;

  matrix_mem_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .eng_mem_operation (eng_mem_operation),
    .eng_addr          (eng_addr),
    .eng_wdata         (eng_wdata),
    .eng_rdata         (eng_rdata),
    .eng_opdone        (eng_opdone),
    .host_req          (host_req),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rdata        (host_rdata),
    .host_ack          (host_ack),
    .sram_csb          (sram_csb),
    .sram_web          (sram_web),
    .sram_addr         (sram_addr),
    .sram_din          (sram_din),
    .sram_dout         (sram_dout),
    .err_oob           (err_oob)
  );

  // One-cycle synchronous SRAM model
  logic [31:0] mem [0:(1<<AW)-1];
  int          sel_count = 0;
  always @(posedge clk) begin
    if (!sram_csb) begin
      sel_count <= sel_count + 1;
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout <= mem[sram_addr];
    end
  end

  typedef struct {
    owner_e      owner;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (eng_opdone || host_ack)) begin
      if (eng_opdone && host_ack) check("dual_done", 32'd1, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'b0, host_ack}, {31'b0, eng_opdone});
        check("unexpected_done_count", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_owner", {31'b0, ~eng_opdone}, {31'b0, e.owner});
        if (e.chk) check("rdata", eng_opdone ? eng_rdata : host_rdata, e.data);
      end
    end
  end

  task automatic eng_do(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk, input logic [31:0] exp, input int lat, input bit rel);
    int n = 0;
    sb_q.push_back('{OWN_ENG, chk, exp});
    eng_mem_operation = op;
    eng_addr          = addr;
    eng_wdata         = wdata;
    do begin
      @(posedge clk); #1; n++;
    end while (!eng_opdone && n < 100);
    check("eng_done_seen", {31'b0, eng_opdone}, 32'd1);
    if (eng_opdone && lat != 0) check("eng_latency", n, lat);
    @(posedge clk); #1;
    if (rel) begin
      eng_mem_operation = MEM_NONE;
      @(posedge clk); #1;
    end
  endtask

  task automatic host_do(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit chk, input logic [31:0] exp, input int lat, input bit rel);
    int n = 0;
    sb_q.push_back('{OWN_HOST, chk, exp});
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    do begin
      @(posedge clk); #1; n++;
    end while (!host_ack && n < 100);
    check("host_ack_seen", {31'b0, host_ack}, 32'd1);
    if (host_ack && lat != 0) check("host_latency", n, lat);
    @(posedge clk); #1;
    if (rel) begin
      host_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] vals [5] = '{32'h2, 32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    int bad = 0;
    int s0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csb", {31'b0, sram_csb}, 32'd1);
    check("rst_web", {31'b0, sram_web}, 32'd1);
    check("rst_addr", {23'b0, sram_addr}, 32'd0);
    check("rst_din", sram_din, 32'd0);
    check("rst_eng_rdata", eng_rdata, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sram_csb !== 1'b1 || eng_opdone !== 1'b0 || host_ack !== 1'b0 || err_oob !== 1'b0) bad++;
    end
    check("reset_idle", bad, 32'd0);

    host_do(1'b1, 32'h0, 32'h2, 1'b0, 32'h0, 2, 1'b1);
    eng_do(MEM_READ, 32'h0, 32'h0, 1'b1, 32'h2, 3, 1'b1);
    for (int i = 1; i < 5; i++) host_do(1'b1, i, vals[i], 1'b0, 32'h0, 2, 1'b1);

    for (int i = 0; i < 5; i++)
      eng_do(MEM_READ, i, 32'h0, 1'b1, vals[i], (i == 0) ? 3 : 4, i == 4);

    host_do(1'b0, 32'h4, 32'h0, 1'b1, 32'h44, 3, 1'b1);

    // Tie: ENG(1), HOST(3), ENG(2), HOST(4) in that order
    fork
      begin
        eng_do(MEM_READ, 32'h1, 32'h0, 1'b1, 32'h11, 0, 1'b0);
        eng_do(MEM_READ, 32'h2, 32'h0, 1'b1, 32'h22, 0, 1'b1);
      end
      begin
        #2;
        host_do(1'b0, 32'h3, 32'h0, 1'b1, 32'h33, 0, 1'b0);
        host_do(1'b0, 32'h4, 32'h0, 1'b1, 32'h44, 0, 1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    s0 = sel_count;
    eng_do(MEM_WRITE, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1);
    check("oob_no_select", sel_count, s0);
    check("oob_flag", {31'b0, err_oob}, 32'd1);
    host_do(1'b0, 32'h0, 32'h0, 1'b1, 32'h2, 3, 1'b1);
    eng_do(MEM_READ, 32'h1000_0000, 32'h0, 1'b1, 32'h0, 3, 1'b1);
    check("oob_sticky", {31'b0, err_oob}, 32'd1);

    eng_mem_operation = MEM_READ;
    eng_addr          = 32'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_csb", {31'b0, sram_csb}, 32'd1);
    check("midrst_opdone", {31'b0, eng_opdone}, 32'd0);
    check("midrst_err", {31'b0, err_oob}, 32'd0);
    eng_mem_operation = MEM_NONE;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    eng_do(MEM_READ, 32'h3, 32'h0, 1'b1, 32'h33, 3, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
